dft_bin_acc: RTL and testbench

- Consumer-side partner of the row NCO. Reads one frame of audio samples from the sample buffer and mixes each sample with the two NCO tone pairs (cos0/sin0, cos1/sin1).
- Accumulates complex correlation for two frequency bins per spectrogram row, then presents per-bin real/imag sums to the pixel writer through a valid/ready handshake.
- Also drives the NCO START pulse, so NCO and sample stream stay cycle-aligned.

---
 rtl/dft_bin_acc_pkg.sv | 20 ++
 rtl/dft_bin_acc_cmac_bin.sv | 65 ++++++
 rtl/dft_bin_acc.sv | 177 +++++++++++++++++
 tb/tb_dft_bin_acc.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/dft_bin_acc_pkg.sv
// Shared types and default widths for the two-bin DFT accumulator.
// DEF_NCO_LAT must match the latency of the NCO instance paired with this block.
package dft_bin_acc_pkg;
  localparam int DEF_N_LOG2   = 7;
  localparam int DEF_SAMPLE_W = 16;
  localparam int DEF_NCO_W    = 18;
  localparam int DEF_ACC_W    = 42;
  localparam int DEF_NCO_LAT  = 6;
  localparam int POW_W        = 36;
  localparam int MAG_TOP_W    = 18;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    ACC,
    FLUSH,
    MAG,
    DONE
  } state_t;
endpackage

// File: rtl/dft_bin_acc_cmac_bin.sv
// One frequency bin: sample times cos/sin, then accumulate re = sum x*cos, im = -sum x*sin.
// clr dominates en and also discards any product already in flight.
module cmac_bin
  import dft_bin_acc_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int NCO_W    = DEF_NCO_W,
  parameter int ACC_W    = DEF_ACC_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       en,
  input  logic signed [SAMPLE_W-1:0] sample,
  input  logic signed [NCO_W-1:0]    coef_cos,
  input  logic signed [NCO_W-1:0]    coef_sin,
  output logic signed [ACC_W-1:0]    re,
  output logic signed [ACC_W-1:0]    im
);
  localparam int PROD_W = SAMPLE_W + NCO_W;

  logic signed [PROD_W-1:0] x_ext;
  logic signed [PROD_W-1:0] c_ext;
  logic signed [PROD_W-1:0] s_ext;
  logic signed [PROD_W-1:0] mul_cos;
  logic signed [PROD_W-1:0] mul_sin;
  logic signed [PROD_W-1:0] prod_re_p1;
  logic signed [PROD_W-1:0] prod_im_p1;
  logic                     vld_p1;

  function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
    return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

  assign x_ext   = PROD_W'(sample);
  assign c_ext   = PROD_W'(coef_cos);
  assign s_ext   = PROD_W'(coef_sin);
  assign mul_cos = x_ext * c_ext;
  assign mul_sin = x_ext * s_ext;

  // Stage 1: full-precision products; the sin product is negated here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= en && !clr;
  end

  always_ff @(posedge clk) begin
    prod_re_p1 <= mul_cos;
    prod_im_p1 <= -mul_sin;
  end

  // Stage 2: sign-extend and accumulate, wrapping modulo 2^ACC_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      re <= '0;
      im <= '0;
    end else if (clr) begin
      re <= '0;
      im <= '0;
    end else if (vld_p1) begin
      re <= re + sext_prod(prod_re_p1);
      im <= im + sext_prod(prod_im_p1);
    end
  end
endmodule

// File: rtl/dft_bin_acc.sv
// Two-bin DFT correlator: primes the NCO, streams one frame of samples, hands sums downstream.
// Optional power output enabled by defining DFT_BIN_ACC_MAG_EN.
module dft_bin_acc
  import dft_bin_acc_pkg::*;
#(
  parameter int N_LOG2   = DEF_N_LOG2,
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int NCO_W    = DEF_NCO_W,
  parameter int ACC_W    = DEF_ACC_W,
  parameter int NCO_LAT  = DEF_NCO_LAT
) (
  input  logic                       CK,
  input  logic                       RST_N,
  input  logic                       START,
  output logic                       NCO_START,
  input  logic signed [NCO_W-1:0]    cos0,
  input  logic signed [NCO_W-1:0]    sin0,
  input  logic signed [NCO_W-1:0]    cos1,
  input  logic signed [NCO_W-1:0]    sin1,
  output logic [N_LOG2-1:0]          RD_ADDR,
  input  logic signed [SAMPLE_W-1:0] RD_DATA,
  output logic                       BUSY,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY,
  output logic signed [ACC_W-1:0]    re0,
  output logic signed [ACC_W-1:0]    im0,
  output logic signed [ACC_W-1:0]    re1,
  output logic signed [ACC_W-1:0]    im1,
  output logic [POW_W-1:0]           pow0,
  output logic [POW_W-1:0]           pow1
);
  localparam int                CNT_W      = (N_LOG2 > 4) ? N_LOG2 : 4;
  localparam logic [CNT_W-1:0]  PRIME_LAST = CNT_W'(NCO_LAT - 1);
  localparam logic [CNT_W-1:0]  ACC_LAST   = CNT_W'((1 << N_LOG2) - 1);
  localparam logic [CNT_W-1:0]  TWO_LAST   = CNT_W'(1);
  localparam logic [N_LOG2-1:0] ADDR_LAST  = '1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             acc_en;

  // Samples requested during PRIME/ACC land on RD_DATA exactly during the ACC cycles
  assign acc_en = (state == ACC);

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      cnt       <= '0;
      NCO_START <= 1'b0;
      RD_ADDR   <= '0;
      BUSY      <= 1'b0;
      OUT_VALID <= 1'b0;
    end else begin
      NCO_START <= 1'b0;
      if (START && state != DONE) begin
        state     <= PRIME;
        cnt       <= '0;
        NCO_START <= 1'b1;
        RD_ADDR   <= '0;
        BUSY      <= 1'b1;
        OUT_VALID <= 1'b0;
      end else begin
        case (state)
          PRIME: begin
            if (cnt == PRIME_LAST) begin
              state   <= ACC;
              cnt     <= '0;
              RD_ADDR <= N_LOG2'(1);
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ACC: begin
            if (cnt == ACC_LAST) begin
              state   <= FLUSH;
              cnt     <= '0;
              RD_ADDR <= '0;
            end else begin
              cnt <= cnt + 1'b1;
              if (RD_ADDR != ADDR_LAST) RD_ADDR <= RD_ADDR + 1'b1;
            end
          end
          FLUSH: begin
            if (cnt == TWO_LAST) begin
              cnt <= '0;
`ifdef DFT_BIN_ACC_MAG_EN
              state <= MAG;
`else
              state     <= DONE;
              BUSY      <= 1'b0;
              OUT_VALID <= 1'b1;
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          MAG: begin
            if (cnt == TWO_LAST) begin
              state     <= DONE;
              cnt       <= '0;
              BUSY      <= 1'b0;
              OUT_VALID <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DONE: begin
            if (OUT_READY) begin
              state     <= IDLE;
              OUT_VALID <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // The NCO_START pulse doubles as the accumulator clear
  cmac_bin #(.SAMPLE_W(SAMPLE_W), .NCO_W(NCO_W), .ACC_W(ACC_W)) u_bin0 (
    .clk(CK), .rst_n(RST_N), .clr(NCO_START), .en(acc_en), .sample(RD_DATA),
    .coef_cos(cos0), .coef_sin(sin0), .re(re0), .im(im0)
  );

  cmac_bin #(.SAMPLE_W(SAMPLE_W), .NCO_W(NCO_W), .ACC_W(ACC_W)) u_bin1 (
    .clk(CK), .rst_n(RST_N), .clr(NCO_START), .en(acc_en), .sample(RD_DATA),
    .coef_cos(cos1), .coef_sin(sin1), .re(re1), .im(im1)
  );

`ifdef DFT_BIN_ACC_MAG_EN
  logic [POW_W-1:0] sq_re0_p1;
  logic [POW_W-1:0] sq_im0_p1;
  logic [POW_W-1:0] sq_re1_p1;
  logic [POW_W-1:0] sq_im1_p1;

  function automatic logic [POW_W-1:0] square_top(input logic signed [ACC_W-1:0] acc);
    logic signed [MAG_TOP_W-1:0] top;
    logic signed [POW_W-1:0]     w;
    top = acc[ACC_W-1 -: MAG_TOP_W];
    w   = POW_W'(top);
    return w * w;
  endfunction

  function automatic logic [POW_W-1:0] sat_pow(input logic [POW_W-1:0] a, input logic [POW_W-1:0] b);
    logic [POW_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[POW_W] ? {POW_W{1'b1}} : s[POW_W-1:0];
  endfunction

  // MAG cycle 0: square the top bits of each accumulator
  always_ff @(posedge CK) begin
    if (state == MAG && cnt == '0) begin
      sq_re0_p1 <= square_top(re0);
      sq_im0_p1 <= square_top(im0);
      sq_re1_p1 <= square_top(re1);
      sq_im1_p1 <= square_top(im1);
    end
  end

  // MAG cycle 1: saturating sum of squares
  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      pow0 <= '0;
      pow1 <= '0;
    end else if (NCO_START) begin
      pow0 <= '0;
      pow1 <= '0;
    end else if (state == MAG && cnt == TWO_LAST) begin
      pow0 <= sat_pow(sq_re0_p1, sq_im0_p1);
      pow1 <= sat_pow(sq_re1_p1, sq_im1_p1);
    end
  end
`else
  assign pow0 = '0;
  assign pow1 = '0;
`endif
endmodule

// File: tb/tb_dft_bin_acc.sv
// Scoreboard bench for dft_bin_acc: directed frames with hand-computed sums.
module tb_dft_bin_acc;
  localparam int N = 128;
`ifdef DFT_BIN_ACC_MAG_EN
  localparam bit MAG_ON = 1'b1;
  localparam int LAT    = 138;
`else
  localparam bit MAG_ON = 1'b0;
  localparam int LAT    = 136;
`endif

  logic               CK = 1'b0;
  logic               RST_N = 1'b0;
  logic               START = 1'b0;
  logic               OUT_READY = 1'b1;
  logic               NCO_START, BUSY, OUT_VALID;
  logic signed [17:0] cos0 = '0, sin0 = '0, cos1 = '0, sin1 = '0;
  logic [6:0]         RD_ADDR;
  logic signed [15:0] RD_DATA;
  logic signed [41:0] re0, im0, re1, im1;
  logic [35:0]        pow0, pow1;
  logic signed [15:0] mem [N];

  typedef struct {
    string  name;
    longint re0, im0, re1, im1, pow0, pow1;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0, checks = 0;
  int   cyc = 0, nco_cyc = 0, nco_cnt = 0, rise_cyc = 0, done_cnt = 0;
  logic prev_valid = 1'b0;

  dft_bin_acc dut (
    .CK(CK), .RST_N(RST_N), .START(START), .NCO_START(NCO_START),
    .cos0(cos0), .sin0(sin0), .cos1(cos1), .sin1(sin1),
    .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA), .BUSY(BUSY),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .re0(re0), .im0(im0), .re1(re1), .im1(im1), .pow0(pow0), .pow1(pow1)
  );

  always #5 CK = ~CK;
  always @(posedge CK) RD_DATA <= mem[RD_ADDR];
  always @(posedge CK) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge CK) begin
    if (NCO_START === 1'b1) begin
      nco_cyc = cyc;
      nco_cnt++;
    end
    if (OUT_VALID === 1'b1 && prev_valid !== 1'b1) rise_cyc = cyc;
    prev_valid = OUT_VALID;
    if (OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb.unexpected_output_depth", sb.size(), 1);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, ".re0"},  re0,  mon_e.re0);
        check({mon_e.name, ".im0"},  im0,  mon_e.im0);
        check({mon_e.name, ".re1"},  re1,  mon_e.re1);
        check({mon_e.name, ".im1"},  im1,  mon_e.im1);
        check({mon_e.name, ".pow0"}, pow0, mon_e.pow0);
        check({mon_e.name, ".pow1"}, pow1, mon_e.pow1);
        check({mon_e.name, ".latency"}, rise_cyc - nco_cyc, LAT);
      end
      done_cnt++;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge CK);
    #1;
  endtask

  task automatic pulse_start();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic push(input string name, input longint r0, input longint i0,
                      input longint r1, input longint i1, input longint p0, input longint p1);
    exp_t e;
    e.name = name; e.re0 = r0; e.im0 = i0; e.re1 = r1; e.im1 = i1; e.pow0 = p0; e.pow1 = p1;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string name);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < 400 && done_cnt == d0; i++) tick();
    check({name, ".handshake_seen"}, done_cnt - d0, 1);
  endtask

  task automatic fill_const(input int v);
    for (int k = 0; k < N; k++) mem[k] = 16'(v);
  endtask

  task automatic fill_alt(input int v);
    for (int k = 0; k < N; k++) mem[k] = (k % 2 == 0) ? 16'(v) : 16'(-v);
  endtask

  task automatic fill_ramp();
    for (int k = 0; k < N; k++) mem[k] = 16'(k);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int n0;
    int vcount;
    fill_const(0);
    tick(3);
    check("reset.nco_start", NCO_START, 0);
    check("reset.busy", BUSY, 0);
    check("reset.out_valid", OUT_VALID, 0);
    check("reset.rd_addr", RD_ADDR, 0);
    check("reset.re0", re0, 0);
    check("reset.im1", im1, 0);
    check("reset.pow0", pow0, 0);
    RST_N = 1'b1;
    tick(2);

    // Constant cos, constant samples
    cos0 = 18'sh1FFFF; sin0 = '0; cos1 = 18'sh1FFFF; sin1 = '0;
    fill_const(1000);
    push("t1", 64'sd16777088000, 0, 64'sd16777088000, 0, MAG_ON ? 998001 : 0, MAG_ON ? 998001 : 0);
    pulse_start();
    check("t1.nco_start", NCO_START, 1);
    check("t1.busy", BUSY, 1);
    check("t1.rd_addr_prime", RD_ADDR, 0);
    wait_done("t1");
    tick();
    check("t1.idle_busy", BUSY, 0);
    check("t1.idle_valid", OUT_VALID, 0);

    // Alternating samples against sin cancel out
    cos0 = '0; sin0 = 18'sh1FFFF; cos1 = '0; sin1 = 18'sh1FFFF;
    fill_alt(500);
    push("t2a", 0, 0, 0, 0, 0, 0);
    pulse_start();
    wait_done("t2a");

    // Samples of -1 give positive imaginary sum; hold results while READY is low
    fill_const(-1);
    OUT_READY = 1'b0;
    push("t2b", 0, 16777088, 0, 16777088, 0, 0);
    pulse_start();
    for (int i = 0; i < 400 && OUT_VALID !== 1'b1; i++) tick();
    check("hold.valid_rise", OUT_VALID, 1);
    n0 = nco_cnt;
    for (int i = 0; i < 20; i++) begin
      START = (i == 10);
      tick();
    end
    START = 1'b0;
    check("hold.valid_held", OUT_VALID, 1);
    check("hold.busy", BUSY, 0);
    check("hold.im0", im0, 16777088);
    check("hold.no_nco_start", nco_cnt - n0, 0);
    OUT_READY = 1'b1;
    START = 1'b1;
    tick();
    START = 1'b0;
    check("hold.valid_drop", OUT_VALID, 0);
    check("hold.nco_on_handshake", NCO_START, 0);
    check("hold.busy_after", BUSY, 0);
    tick(2);
    check("hold.no_nco_after", nco_cnt - n0, 0);

    // Abort at ACC cycle 40, then a clean ramp frame
    cos0 = 18'sd3; sin0 = -18'sd2; cos1 = -18'sd1; sin1 = 18'sd5;
    fill_ramp();
    n0 = nco_cnt;
    pulse_start();
    tick(46);
    check("abort.rd_addr_acc40", RD_ADDR, 41);
    START = 1'b1;
    tick();
    START = 1'b0;
    check("abort.nco_start", NCO_START, 1);
    check("abort.rd_addr_zero", RD_ADDR, 0);
    push("t3", 24384, 16256, -8128, -40640, 0, MAG_ON ? 2 : 0);
    wait_done("t3");
    check("abort.nco_count", nco_cnt - n0, 2);

    // Asynchronous reset mid-ACC
    pulse_start();
    tick(36);
    check("rst.pre_busy", BUSY, 1);
    #2 RST_N = 1'b0;
    #1;
    check("rst.re0", re0, 0);
    check("rst.im1", im1, 0);
    check("rst.busy", BUSY, 0);
    check("rst.rd_addr", RD_ADDR, 0);
    check("rst.out_valid", OUT_VALID, 0);
    tick();
    RST_N = 1'b1;
    vcount = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (OUT_VALID !== 1'b0 || BUSY !== 1'b0) vcount++;
    end
    check("rst.stays_idle", vcount, 0);

    // Recovery frame after reset
    push("t5", 24384, 16256, -8128, -40640, 0, MAG_ON ? 2 : 0);
    pulse_start();
    wait_done("t5");

    tick(5);
    check("sb.drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
